aes_encipher_block: RTL and testbench

- Iterative AES forward cipher datapath; mirror of the decipher round engine. Encrypts one 128-bit block per `next` request with AES-128 or AES-256.
- Round keys come from the key memory, indexed by the `round` output.
- SubBytes uses one external forward S-box word port, shared with key expansion at core level, one 32-bit word per cycle.
- Sits beside the decipher block under the AES core; the core muxes result/ready by encdec.

---
 rtl/aes_encipher_block.sv | 155 +++++++++++++++
 tb/tb_aes_encipher_block.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 forward cipher round engine: one block per `next`, one S-box word per cycle.
// Latency: ready low 51 cycles (AES-128) / 71 cycles (AES-256); result held in new_block while ready=1.
// Backpressure: none; `next` is accepted only when idle and ignored while busy, with no queuing.
module aes_encipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam logic [3:0] AES128_ROUNDS = 4'd10;
    localparam logic [3:0] AES256_ROUNDS = 4'd14;

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

    state_t       state;
    logic [31:0]  w0, w1, w2, w3;
    logic [3:0]   round_ctr;
    logic [1:0]   sword_ctr;
    logic         keylen_reg;
    logic         ready_reg;

    logic [3:0]   num_rounds;
    logic [127:0] sr_state;
    logic [127:0] mc_state;

    // GF(2^8) doubling, reduction polynomial 0x11b.
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // One column through the {02 03 01 01} circulant.
    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
    endfunction

    // Row r of the state rotates left by r columns.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [31:0] a0, a1, a2, a3;
        a0 = s[127:96];
        a1 = s[95:64];
        a2 = s[63:32];
        a3 = s[31:0];
        return {a0[31:24], a1[23:16], a2[15:8], a3[7:0],
                a1[31:24], a2[23:16], a3[15:8], a0[7:0],
                a2[31:24], a3[23:16], a0[15:8], a1[7:0],
                a3[31:24], a0[23:16], a1[15:8], a2[7:0]};
    endfunction

    // Round datapath and round-count selection from the latched key length.
    always_comb begin
        num_rounds = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;
        sr_state   = shiftrows({w0, w1, w2, w3});
        mc_state   = mixcolumns(sr_state);
    end

    // Present the word under substitution to the shared S-box; zero when not substituting.
    always_comb begin
        sboxw = 32'h0;
        if (state == SBOX) begin
            case (sword_ctr)
                2'd0:    sboxw = w0;
                2'd1:    sboxw = w1;
                2'd2:    sboxw = w2;
                default: sboxw = w3;
            endcase
        end
    end

    // Control FSM and state register: init key add, 4 substitution cycles, then the linear round layer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            w0         <= 32'h0;
            w1         <= 32'h0;
            w2         <= 32'h0;
            w3         <= 32'h0;
            round_ctr  <= 4'd0;
            sword_ctr  <= 2'd0;
            keylen_reg <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (next) begin
                        round_ctr  <= 4'd0;
                        keylen_reg <= keylen;
                        ready_reg  <= 1'b0;
                        state      <= INIT;
                    end
                end
                INIT: begin
                    {w0, w1, w2, w3} <= block ^ round_key;
                    round_ctr        <= 4'd1;
                    sword_ctr        <= 2'd0;
                    state            <= SBOX;
                end
                SBOX: begin
                    case (sword_ctr)
                        2'd0:    w0 <= new_sboxw;
                        2'd1:    w1 <= new_sboxw;
                        2'd2:    w2 <= new_sboxw;
                        default: w3 <= new_sboxw;
                    endcase
                    sword_ctr <= sword_ctr + 2'd1;
                    if (sword_ctr == 2'd3) begin
                        state <= MAIN;
                    end
                end
                MAIN: begin
                    if (round_ctr < num_rounds) begin
                        {w0, w1, w2, w3} <= mc_state ^ round_key;
                        round_ctr        <= round_ctr + 4'd1;
                        sword_ctr        <= 2'd0;
                        state            <= SBOX;
                    end else begin
                        // Final round skips MixColumns; round stays at num_rounds.
                        {w0, w1, w2, w3} <= sr_state ^ round_key;
                        ready_reg        <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign round     = round_ctr;
    assign new_block = {w0, w1, w2, w3};
    assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: models key memory and S-box, scoreboards every completed run.
// Reference cipher is a byte-level AES with S-box derived from GF(2^8) inverse + affine map.
// A monitor pops expected results on every rising edge of ready, independent of stimulus.
module tb_aes_encipher_block;

    logic         clk = 1'b0;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    int total = 0;
    int bad   = 0;

    logic [7:0]  sbox_tbl [256];
    logic [31:0] ek [60];

    typedef struct {
        logic [127:0] ct;
        logic [3:0]   rnd;
        int           lowcyc;
    } exp_t;
    exp_t sbq[$];

    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_encipher_block dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // Combinational S-box and key memory seen by the DUT.
    assign new_sboxw = {sbox_tbl[sboxw[31:24]], sbox_tbl[sboxw[23:16]],
                        sbox_tbl[sboxw[15:8]],  sbox_tbl[sboxw[7:0]]};
    assign round_key = (round <= 4'd14) ?
                       {ek[4*int'(round)], ek[4*int'(round)+1], ek[4*int'(round)+2], ek[4*int'(round)+3]} :
                       128'h0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
    endfunction

    // FIPS-197 key expansion into the key memory; AES-128 keys occupy key[255:128].
    task automatic expand_key(input logic [255:0] key, input logic klen);
        int nk, nr;
        logic [7:0]  rc;
        logic [31:0] t;
        nk = klen ? 8 : 4;
        nr = klen ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) ek[i] = 32'h0;
        for (int i = 0; i < nk; i++) ek[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = ek[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            ek[i] = ek[i-nk] ^ t;
        end
    endtask

    function automatic logic [7:0] rkbyte(input int r, input int i);
        logic [31:0] w;
        w = ek[4*r + i/4];
        return w[31 - 8*(i%4) -: 8];
    endfunction

    // Textbook cipher over a 16-byte array; byte 4c+r is row r of column c.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic klen);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        int nr;
        nr = klen ? 14 : 10;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rkbyte(0, i);
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tbl[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c+rr] = s[4*((c+rr)%4) + rr];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkbyte(r, i);
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic push_exp(input logic [127:0] ct, input logic klen);
        exp_t e;
        e.ct     = ct;
        e.rnd    = klen ? 4'd14 : 4'd10;
        e.lowcyc = klen ? 71 : 51;
        sbq.push_back(e);
    endtask

    // Issue one `next` pulse at a negedge; returns at the negedge after acceptance (INIT cycle).
    task automatic start_run(input logic [255:0] key, input logic klen, input logic [127:0] pt,
                             input logic [127:0] ct, input bit expect_result);
        @(negedge clk);
        expand_key(key, klen);
        keylen = klen;
        block  = pt;
        if (expect_result) push_exp(ct, klen);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL wait_done: timeout after %0d cycles, ready still 0", budget);
        end
    endtask

    task automatic check_idle_reset_state(input string tag);
        chk({tag, "_ready"},     128'(ready),  128'd1);
        chk({tag, "_round"},     128'(round),  128'd0);
        chk({tag, "_new_block"}, new_block,    128'h0);
        chk({tag, "_sboxw"},     128'(sboxw),  128'h0);
    endtask

    // Monitor: each rising edge of ready outside reset completes one scoreboarded run.
    initial begin : monitor
        int   low;
        logic prev_rdy;
        exp_t e;
        low      = 0;
        prev_rdy = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (reset !== 1'b0) begin
                low      = 0;
                prev_rdy = 1'b1;
            end else begin
                if (ready !== 1'b1) begin
                    low++;
                end else begin
                    if (!prev_rdy) begin
                        if (sbq.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_result: got %h with no run pending", new_block);
                        end else begin
                            e = sbq.pop_front();
                            chk("ciphertext",  new_block,   e.ct);
                            chk("final_round", 128'(round), 128'(e.rnd));
                            chk("busy_cycles", 128'(low),   128'(e.lowcyc));
                        end
                    end
                    low = 0;
                end
                prev_rdy = ready;
            end
        end
    end

    initial begin : stimulus
        logic [31:0]  exp_words [4];
        logic [255:0] rkey;
        logic [127:0] rpt;
        logic         rkl;

        reset  = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = 128'h0;
        init_sbox();
        expand_key(KEY_C1, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_reset_state("por");

        // FIPS-197 C.1 with S-box port observation during the first substitution pass.
        exp_words[0] = 32'h00102030;
        exp_words[1] = 32'h40506070;
        exp_words[2] = 32'h8090a0b0;
        exp_words[3] = 32'hc0d0e0f0;
        start_run(KEY_C1, 1'b0, PT_C, CT_C1, 1'b1);
        chk("ready_fall", 128'(ready), 128'd0);
        chk("sboxw_init", 128'(sboxw), 128'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("sboxw_w%0d", i), 128'(sboxw), 128'(exp_words[i]));
        end
        wait_done(200);

        // FIPS-197 C.3.
        start_run(KEY_C3, 1'b1, PT_C, CT_C3, 1'b1);
        wait_done(200);

        // Reset mid-run aborts with no result.
        start_run(KEY_C1, 1'b0, PT_C, CT_C1, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_reset_state("abort");

        // Stray next pulses and keylen toggles while busy must not disturb the run.
        start_run(KEY_C1, 1'b0, PT_C, CT_C1, 1'b1);
        repeat (4) @(negedge clk);
        next   = 1'b1;
        keylen = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (24) @(negedge clk);
        next   = 1'b1;
        keylen = 1'b0;
        @(negedge clk);
        next   = 1'b0;
        keylen = 1'b1;
        wait_done(200);
        keylen = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_extra_run", 128'(ready), 128'd1);

        // Back-to-back: next held high, keylen/key switched in the single idle cycle.
        @(negedge clk);
        expand_key(KEY_C1, 1'b0);
        keylen = 1'b0;
        block  = PT_C;
        push_exp(CT_C1, 1'b0);
        next = 1'b1;
        @(negedge clk);
        wait_done(200);
        expand_key(KEY_C3, 1'b1);
        keylen = 1'b1;
        push_exp(CT_C3, 1'b1);
        @(negedge clk);
        chk("b2b_gap_one_cycle", 128'(ready), 128'd0);
        repeat (10) @(negedge clk);
        next = 1'b0;
        wait_done(200);

        // Randomized runs checked against the reference cipher.
        for (int n = 0; n < 8; n++) begin
            rkl  = 1'($urandom_range(0, 1));
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (!rkl) rkey[127:0] = 128'h0;
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(rkey, rkl);
            start_run(rkey, rkl, rpt, ref_encrypt(rpt, rkl), 1'b1);
            wait_done(200);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
